// File: rtl/pll_lock_reset_seq.sv
// PLL reset pulse, lock qualification and staggered per-domain reset release on the PLL reference clock.
// Define PLL_LOCK_RETRY_EN to retry through PLL_RST after a lock timeout instead of parking in FAULT.
module pll_lock_reset_seq #(
    parameter int unsigned SYNC_STAGES         = 2,
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
    parameter int unsigned NUM_RESETS          = 4,
    parameter int unsigned RST_STAGGER_CYCLES  = 8,
    parameter int unsigned LOSS_CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  sw_restart,
    output logic                  pll_rst,
    output logic [NUM_RESETS-1:0] dom_rst_n,
    output logic                  ready,
    output logic                  timeout_err,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_B   = (LOCK_TIMEOUT_CYCLES > RST_STAGGER_CYCLES) ? LOCK_TIMEOUT_CYCLES : RST_STAGGER_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RELEASE,
        ST_RUN,
        ST_FAULT
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    locked_s;
    logic                    pll_rst_q, pll_rst_d;
    logic [NUM_RESETS-1:0]   dom_rst_n_q, dom_rst_n_d, dom_shift;
    logic                    ready_q, ready_d;
    logic                    timeout_err_q, timeout_err_d;
    logic [LOSS_CNT_W-1:0]   loss_cnt_q, loss_cnt_d;

    // pll_locked crosses from the PLL domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_PLL_RST;
            cnt_q         <= '0;
            pll_rst_q     <= 1'b1;
            dom_rst_n_q   <= '0;
            ready_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            loss_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pll_rst_q     <= pll_rst_d;
            dom_rst_n_q   <= dom_rst_n_d;
            ready_q       <= ready_d;
            timeout_err_q <= timeout_err_d;
            loss_cnt_q    <= loss_cnt_d;
        end
    end

    // Next-state and next-output logic; outputs are registered copies of the *_d values
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pll_rst_d     = pll_rst_q;
        dom_rst_n_d   = dom_rst_n_q;
        ready_d       = ready_q;
        timeout_err_d = 1'b0;
        loss_cnt_d    = loss_cnt_q;
        cnt_inc       = cnt_q + CNT_W'(1);
        dom_shift     = (dom_rst_n_q << 1) | NUM_RESETS'(1);

        if (sw_restart) begin
            state_d     = ST_PLL_RST;
            cnt_d       = '0;
            pll_rst_d   = 1'b1;
            dom_rst_n_d = '0;
            ready_d     = 1'b0;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    pll_rst_d   = 1'b1;
                    dom_rst_n_d = '0;
                    ready_d     = 1'b0;
                    if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
                        state_d   = ST_WAIT_LOCK;
                        cnt_d     = '0;
                        pll_rst_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        timeout_err_d = 1'b1;
                        cnt_d         = '0;
                        pll_rst_d     = 1'b1;
`ifdef PLL_LOCK_RETRY_EN
                        state_d       = ST_PLL_RST;
`else
                        state_d       = ST_FAULT;
`endif
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state_d     = ST_RELEASE;
                        cnt_d       = '0;
                        dom_rst_n_d = NUM_RESETS'(1);
                        if (NUM_RESETS == 1) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_RELEASE: begin
                    if (!locked_s) begin
                        state_d     = ST_WAIT_LOCK;
                        cnt_d       = '0;
                        dom_rst_n_d = '0;
                        ready_d     = 1'b0;
                    end else if (cnt_q == CNT_W'(RST_STAGGER_CYCLES - 1)) begin
                        // one more domain released per stagger period, lowest index first
                        cnt_d       = '0;
                        dom_rst_n_d = dom_shift;
                        if (&dom_shift) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d     = ST_WAIT_LOCK;
                        cnt_d       = '0;
                        dom_rst_n_d = '0;
                        ready_d     = 1'b0;
                        if (loss_cnt_q != {LOSS_CNT_W{1'b1}}) begin
                            loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
                        end
                    end
                end
                ST_FAULT: begin
                    pll_rst_d   = 1'b1;
                    dom_rst_n_d = '0;
                    ready_d     = 1'b0;
                end
                default: begin
                    state_d     = ST_PLL_RST;
                    cnt_d       = '0;
                    pll_rst_d   = 1'b1;
                    dom_rst_n_d = '0;
                    ready_d     = 1'b0;
                end
            endcase
        end
    end

    assign pll_rst       = pll_rst_q;
    assign dom_rst_n     = dom_rst_n_q;
    assign ready         = ready_q;
    assign timeout_err   = timeout_err_q;
    assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq with short timing parameters; stimulus driven and outputs sampled on negedge.
module tb_pll_lock_reset_seq;

    localparam int unsigned NR = 4;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pll_locked;
    logic          sw_restart;
    logic          pll_rst;
    logic [NR-1:0] dom_rst_n;
    logic          ready;
    logic          timeout_err;
    logic [LW-1:0] lock_loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int to_cnt   = 0;
    int viol     = 0;
    logic [NR-1:0] therm;

    always #5 clk = ~clk;

    pll_lock_reset_seq #(
        .SYNC_STAGES         (2),
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (16),
        .LOCK_TIMEOUT_CYCLES (100),
        .NUM_RESETS          (NR),
        .RST_STAGGER_CYCLES  (2),
        .LOSS_CNT_W          (LW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .sw_restart    (sw_restart),
        .pll_rst       (pll_rst),
        .dom_rst_n     (dom_rst_n),
        .ready         (ready),
        .timeout_err   (timeout_err),
        .lock_loss_cnt (lock_loss_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input logic lvl, input string tag);
        int n;
        n = 0;
        while (ready !== lvl && n < 200) begin
            tick(1);
            n++;
        end
        if (ready !== lvl) check(tag, 32'(ready), 32'(lvl));
    endtask

    // Timeout pulse counter plus ordering / ready invariants, sampled every cycle
    always @(negedge clk) begin
        if (timeout_err) to_cnt++;
        if (rst_n) begin
            therm = dom_rst_n + NR'(1);
            if ((therm & dom_rst_n) != '0) viol++;
            if (ready && (dom_rst_n != '1 || pll_rst)) viol++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] dom_acc;
        logic          ready_acc;
        int            exp_loss;
        int            n;

        rst_n      = 1'b0;
        pll_locked = 1'b0;
        sw_restart = 1'b0;
        tick(3);
        check("rst_pll_rst", 32'(pll_rst), 1);
        check("rst_dom", 32'(dom_rst_n), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        check("rst_loss", 32'(lock_loss_cnt), 0);

        // Test 1: power-up sequence, lock raised at cycle 10
        rst_n = 1'b1;
        tick(1);  check("t1_pll_rst_c1", 32'(pll_rst), 1);
        tick(2);  check("t1_pll_rst_c3", 32'(pll_rst), 1);
        tick(1);  check("t1_pll_rst_c4", 32'(pll_rst), 0);
        tick(6);  pll_locked = 1'b1;
        tick(18); check("t1_dom_c28", 32'(dom_rst_n), 32'h0);
        tick(1);  check("t1_dom_c29", 32'(dom_rst_n), 32'h1);
        tick(2);  check("t1_dom_c31", 32'(dom_rst_n), 32'h3);
        tick(2);  check("t1_dom_c33", 32'(dom_rst_n), 32'h7);
        tick(1);  check("t1_ready_c34", 32'(ready), 0);
        tick(1);  check("t1_dom_c35", 32'(dom_rst_n), 32'hF);
                  check("t1_ready_c35", 32'(ready), 1);
                  check("t1_pll_rst_c35", 32'(pll_rst), 0);

        // Test 2: one-cycle lock drop in RUN
        tick(5);  pll_locked = 1'b0;
        tick(1);  pll_locked = 1'b1;
        tick(1);  check("t2_ready_e2", 32'(ready), 1);
        tick(1);  check("t2_dom_e3", 32'(dom_rst_n), 0);
                  check("t2_ready_e3", 32'(ready), 0);
                  check("t2_loss_e3", 32'(lock_loss_cnt), 1);
                  check("t2_pll_rst_e3", 32'(pll_rst), 0);
        tick(16); check("t2_dom_c59", 32'(dom_rst_n), 32'h0);
        tick(1);  check("t2_dom_c60", 32'(dom_rst_n), 32'h1);
        tick(5);  check("t2_ready_c65", 32'(ready), 0);
        tick(1);  check("t2_ready_c66", 32'(ready), 1);
                  check("t2_dom_c66", 32'(dom_rst_n), 32'hF);

        // Test 3: restart, then flapping lock never qualifies
        tick(1);  sw_restart = 1'b1;
        tick(1);  sw_restart = 1'b0;
        check("t3_sw_dom", 32'(dom_rst_n), 0);
        check("t3_sw_pll_rst", 32'(pll_rst), 1);
        dom_acc   = '0;
        ready_acc = 1'b0;
        for (int k = 0; k < 12; k++) begin
            pll_locked = 1'b0;
            tick(1);
            dom_acc |= dom_rst_n;
            ready_acc |= ready;
            pll_locked = 1'b1;
            for (int j = 0; j < 9; j++) begin
                tick(1);
                dom_acc |= dom_rst_n;
                ready_acc |= ready;
            end
        end
        check("t3_flap_dom", 32'(dom_acc), 0);
        check("t3_flap_ready", 32'(ready_acc), 0);
        check("t3_flap_loss", 32'(lock_loss_cnt), 1);

        // Test 5: sw_restart while dom_rst_n is 0011
        n = 0;
        while (dom_rst_n !== 4'b0011 && n < 100) begin
            tick(1);
            n++;
        end
        check("t5_reach_0011", 32'(dom_rst_n), 32'h3);
        sw_restart = 1'b1;
        pll_locked = 1'b0;
        tick(1);  sw_restart = 1'b0;
        check("t5_dom", 32'(dom_rst_n), 0);
        check("t5_pll_rst", 32'(pll_rst), 1);
        check("t5_ready", 32'(ready), 0);
        check("t5_loss", 32'(lock_loss_cnt), 1);

        // Test 4: lock held low until timeout
        tick(3);  check("t4_pll_rst_c3", 32'(pll_rst), 1);
        tick(1);  check("t4_pll_rst_c4", 32'(pll_rst), 0);
        tick(99); check("t4_to_c103", 32'(timeout_err), 0);
        tick(1);  check("t4_to_c104", 32'(timeout_err), 1);
                  check("t4_pll_rst_c104", 32'(pll_rst), 1);
        tick(1);  check("t4_to_c105", 32'(timeout_err), 0);
        tick(3);
`ifdef PLL_LOCK_RETRY_EN
        check("t4_retry_pll_rst_c108", 32'(pll_rst), 0);
`else
        check("t4_fault_pll_rst_c108", 32'(pll_rst), 1);
`endif
        tick(42);
`ifdef PLL_LOCK_RETRY_EN
        check("t4_retry_pll_rst_c150", 32'(pll_rst), 0);
`else
        check("t4_fault_pll_rst_c150", 32'(pll_rst), 1);
`endif
        check("t4_dom_c150", 32'(dom_rst_n), 0);
        check("t4_to_pulses", 32'(to_cnt), 1);
        sw_restart = 1'b1;
        pll_locked = 1'b1;
        tick(1);  sw_restart = 1'b0;
        check("t4_restart_pll_rst", 32'(pll_rst), 1);
        tick(4);  check("t4_restart_pll_rst_c4", 32'(pll_rst), 0);

        // Test 6: repeated losses in RUN saturate the counter
        exp_loss = 1;
        for (int k = 0; k < 300; k++) begin
            wait_ready(1'b1, "t6_ready_rise");
            pll_locked = 1'b0;
            tick(1);
            pll_locked = 1'b1;
            wait_ready(1'b0, "t6_ready_fall");
            exp_loss = (exp_loss == 255) ? 255 : exp_loss + 1;
            check("t6_loss_cnt", 32'(lock_loss_cnt), 32'(exp_loss));
        end
        check("t6_loss_sat", 32'(lock_loss_cnt), 255);
        check("timeout_total", 32'(to_cnt), 1);
        check("invariants", 32'(viol), 0);

        // Async reset in the middle of RELEASE
        n = 0;
        while (dom_rst_n !== 4'b0011 && n < 100) begin
            tick(1);
            n++;
        end
        check("t6_reach_0011", 32'(dom_rst_n), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pll_rst", 32'(pll_rst), 1);
        check("arst_dom", 32'(dom_rst_n), 0);
        check("arst_ready", 32'(ready), 0);
        check("arst_timeout", 32'(timeout_err), 0);
        check("arst_loss", 32'(lock_loss_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check("arst_after_pll_rst", 32'(pll_rst), 1);
        check("arst_after_dom", 32'(dom_rst_n), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
